ram_ctrl: RTL and testbench

Synchronous word-wide RAM with a cs/we/oe request interface and a ready handshake. It is the storage stage downstream of the program loader: the loader writes 32-bit little-endian words at byte addresses, then the core fetch and load/store paths read them back. The block adds a programmable access latency so upstream masters are exercised against a memory that is not zero-wait.

---
 rtl/ram_pkg.sv | 26 ++
 rtl/ram_array.sv | 38 +++
 rtl/ram_ctrl.sv | 148 ++++++++++++++
 tb/tb_ram_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for the ram_ctrl slice
// Purpose : FSM state enum, request op encoding, default error word and
//           the parity helper used when RAM_PARITY_EN is defined.
// Ports   : none (package).
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int unsigned DATA_W           = 32;
  localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEAD_BEEF;

  // Even parity: the stored bit makes the XOR of all 33 bits zero.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - single-port storage array for ram_ctrl
// Purpose : DEPTH x WIDTH word store; synchronous write, combinational read
//           so the controller can capture read data on its DONE edge.
//           Under RAM_PARITY_EN a debug-only task flips a stored parity bit
//           (the MSB of the word) for fault injection.
// Ports   : clk     - clock
//           i_we    - write enable
//           i_addr  - word index
//           i_wdata - write word
//           o_rdata - word at i_addr
module ram_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 10
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  // Contents are intentionally not reset.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

`ifdef RAM_PARITY_EN
  task automatic flip_parity(input int unsigned idx);
    r_mem[idx[AW-1:0]][WIDTH-1] <= ~r_mem[idx[AW-1:0]][WIDTH-1];
  endtask
`endif

endmodule

// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - word RAM with cs/we/oe requests and programmable latency
// Purpose : accepts one request at a time, waits WAIT_CYCLES, then performs
//           the access and pulses ready for one cycle. Out-of-range or
//           illegal (we and oe together) requests pulse err with ready.
//           Optional macro RAM_PARITY_EN adds a stored even-parity bit per
//           word and drives parity_err on a read mismatch.
// Ports   : clk, rst_n (async active-low)
//           cs, we, oe        - request strobes
//           address           - byte address, bits [1:0] ignored
//           data_input        - write data
//           data_output       - read data, held until next completed read
//           ready             - one-cycle completion pulse
//           err               - one-cycle error pulse, coincident with ready
//           parity_err        - one-cycle read parity mismatch pulse
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ERR_WORD    = ERR_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        we,
  input  logic        oe,
  input  logic [31:0] address,
  input  logic [31:0] data_input,
  output logic [31:0] data_output,
  output logic        ready,
  output logic        err,
  output logic        parity_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
`ifdef RAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [29:0] r_idx;
  logic [31:0] r_wdata;
  op_t         r_op;
  logic        r_illegal;

  logic w_req_ok, w_req_bad, w_oor;
  logic w_done, w_mem_we, w_rd_load;
  logic [MEM_W-1:0] w_mem_wdata, w_mem_rdata;
  logic w_unused_addr_lsb;

  assign w_req_ok          = cs & (we ^ oe);
  assign w_req_bad         = cs & we & oe;
  assign w_oor             = ({2'b00, r_idx} >= 32'(DEPTH_WORDS));
  assign w_unused_addr_lsb = ^address[1:0];

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE:    if (w_req_ok) r_cnt <= 4'(WAIT_CYCLES);
        WAIT:    r_cnt <= r_cnt - 4'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Request latch: inputs are ignored once a request has been accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_wdata   <= '0;
      r_op      <= OP_RD;
      r_illegal <= 1'b0;
    end else if (r_state == IDLE && (w_req_ok || w_req_bad)) begin
      r_idx     <= address[31:2];
      r_wdata   <= data_input;
      r_op      <= we ? OP_WR : OP_RD;
      r_illegal <= w_req_bad;
    end
  end

  // Next-state logic. Illegal requests skip the wait and complete at once.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req_bad)     w_next = DONE;
        else if (w_req_ok) w_next = (WAIT_CYCLES == 0) ? DONE : WAIT;
      end
      WAIT:    if (r_cnt <= 4'd1) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    w_done    = (r_state == DONE);
    w_mem_we  = w_done & ~r_illegal & (r_op == OP_WR) & ~w_oor;
    w_rd_load = w_done & ~r_illegal & (r_op == OP_RD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_output <= '0;
      ready       <= 1'b0;
      err         <= 1'b0;
    end else begin
      ready <= w_done;
      err   <= w_done & (r_illegal | w_oor);
      if (w_rd_load) data_output <= w_oor ? ERR_WORD : w_mem_rdata[DATA_W-1:0];
    end
  end

`ifdef RAM_PARITY_EN
  logic r_parity_err;
  assign w_mem_wdata = {even_parity(r_wdata), r_wdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_parity_err <= 1'b0;
    else        r_parity_err <= w_rd_load & ~w_oor & (^w_mem_rdata);
  end
  assign parity_err = r_parity_err;
`else
  assign w_mem_wdata = r_wdata;
  assign parity_err  = 1'b0;
`endif

  ram_array #(
    .DEPTH (DEPTH_WORDS),
    .WIDTH (MEM_W),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (r_idx[AW-1:0]),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_ram_ctrl.sv
// tb/tb_ram_ctrl.sv - randomized self-checking bench for ram_ctrl
// Two instances: u_dut_a (1024 words, 2 wait cycles) and u_dut_b
// (16 words, zero wait). sel steers the shared request bus to one of them.
// Optional macro RAM_PARITY_EN enables the parity fault-injection case.
`timescale 1ns/1ps
module tb_ram_ctrl;

  localparam logic [31:0] ERR_W = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cs, we, oe, sel;
  logic [31:0] address, data_input;
  logic        cs_a, cs_b;
  logic [31:0] dout_a, dout_b, dout;
  logic        rdy_a, rdy_b, rdy, err_a, err_b, errs, perr_a, perr_b, perr;

  assign cs_a = cs & ~sel;
  assign cs_b = cs & sel;
  assign dout = sel ? dout_b : dout_a;
  assign rdy  = sel ? rdy_b  : rdy_a;
  assign errs = sel ? err_b  : err_a;
  assign perr = sel ? perr_b : perr_a;

  ram_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cs(cs_a), .we(we), .oe(oe), .address(address),
    .data_input(data_input), .data_output(dout_a), .ready(rdy_a), .err(err_a),
    .parity_err(perr_a));

  ram_ctrl #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cs(cs_b), .we(we), .oe(oe), .address(address),
    .data_input(data_input), .data_output(dout_b), .ready(rdy_b), .err(err_b),
    .parity_err(perr_b));

  // Reference model: one word map per instance plus last completed read.
  logic [31:0] mem_a [int unsigned];
  logic [31:0] mem_b [int unsigned];
  logic [31:0] last_a, last_b;
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned depth_of();
    return sel ? 16 : 1024;
  endfunction

  function automatic bit known(input int unsigned idx);
    return sel ? mem_b.exists(idx) : mem_a.exists(idx);
  endfunction

  function automatic logic [31:0] mread(input int unsigned idx);
    if (sel) return mem_b.exists(idx) ? mem_b[idx] : 32'hx;
    return mem_a.exists(idx) ? mem_a[idx] : 32'hx;
  endfunction

  task automatic transact(input bit w, input bit r, input logic [31:0] addr,
                          input logic [31:0] wd, input bit exp_perr);
    int unsigned idx, lat;
    bit          illegal, oor;
    logic [31:0] exp_d;
    int          n;
    idx     = addr >> 2;
    illegal = w & r;
    oor     = idx >= depth_of();
    lat     = illegal ? 1 : (sel ? 1 : 3);
    exp_d   = sel ? last_b : last_a;
    if (r && !illegal) exp_d = oor ? ERR_W : mread(idx);

    @(negedge clk);
    cs = 1'b1; we = w; oe = r; address = addr; data_input = wd;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0; oe = 1'b0;
    n = 0;
    while (!rdy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, lat);
    check("err", errs, illegal | oor);
    check("data_output", dout, exp_d);
    check("parity_err", perr, exp_perr);
    @(posedge clk); #1;
    check("ready_one_cycle", rdy, 1'b0);

    if (w && !r && !oor) begin
      if (sel) mem_b[idx] = wd; else mem_a[idx] = wd;
    end
    if (sel) last_b = exp_d; else last_a = exp_d;
  endtask

  // Start a write, assert reset edges_in cycles after acceptance, then release.
  task automatic abort_write(input logic [31:0] addr, input logic [31:0] wd, input int edges_in);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; oe = 1'b0; address = addr; data_input = wd;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
    for (int i = 0; i < edges_in; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_no_ready", rdy, 1'b0);
      @(posedge clk); #1;
    end
    check("rst_data_output", dout, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_a = '0;
    last_b = '0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cs = 1'b0; we = 1'b0; oe = 1'b0; sel = 1'b0;
    address = '0; data_input = '0; last_a = '0; last_b = '0;
    repeat (3) @(negedge clk);
    check("reset_dout_a", dout_a, 32'h0);
    check("reset_ready_a", rdy_a, 1'b0);
    check("reset_err_a", err_a, 1'b0);
    check("reset_perr_a", perr_a, 1'b0);
    check("reset_dout_b", dout_b, 32'h0);
    check("reset_ready_b", rdy_b, 1'b0);
    rst_n = 1'b1;

    // Directed: basic writes/reads with 2 wait cycles.
    transact(1, 0, 32'h0, 32'h1122_3344, 0);
    transact(1, 0, 32'h4, 32'hAABB_CCDD, 0);
    transact(0, 1, 32'h0, 32'h0, 0);
    transact(0, 1, 32'h4, 32'h0, 0);
    transact(0, 1, 32'h6, 32'h0, 0);
    // Out of range read and dropped write.
    transact(0, 1, 32'd4096, 32'h0, 0);
    transact(1, 0, 32'd4096, 32'h9999_9999, 0);
    transact(0, 1, 32'h0, 32'h0, 0);
    // Illegal request leaves memory and data_output alone.
    transact(1, 1, 32'h4, 32'h1234_5678, 0);
    transact(0, 1, 32'h4, 32'h0, 0);
    // cs without we/oe is ignored.
    @(negedge clk);
    cs = 1'b1; we = 1'b0; oe = 1'b0; address = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_no_ready", rdy, 1'b0);
    end
    cs = 1'b0;

    // Reset in WAIT aborts the write (2-wait instance).
    transact(1, 0, 32'h8, 32'hCAFE_F00D, 0);
    abort_write(32'h8, 32'h55, 1);
    transact(0, 1, 32'h8, 32'h0, 0);

    // Zero-wait instance: 1-cycle latency, abort in DONE, small-depth range.
    sel = 1'b1;
    transact(1, 0, 32'h8, 32'h0BAD_C0DE, 0);
    transact(0, 1, 32'h8, 32'h0, 0);
    abort_write(32'h8, 32'h55, 0);
    transact(0, 1, 32'h8, 32'h0, 0);
    transact(0, 1, 32'd64, 32'h0, 0);
    transact(1, 1, 32'h8, 32'h0, 0);

`ifdef RAM_PARITY_EN
    sel = 1'b0;
    transact(1, 0, 32'd12, 32'h1, 0);
    u_dut_a.u_array.flip_parity(3);
    @(posedge clk); #1;
    transact(0, 1, 32'd12, 32'h0, 1);
    transact(1, 0, 32'd12, 32'h1, 0);
    transact(0, 1, 32'd12, 32'h0, 0);
`endif

    // Randomized traffic across both instances.
    for (int i = 0; i < 120; i++) begin
      int unsigned k, idx, dep;
      logic [31:0] a;
      sel = 1'($urandom_range(0, 1));
      dep = depth_of();
      k   = $urandom_range(0, 9);
      idx = ($urandom_range(0, 5) == 0) ? dep + $urandom_range(0, 40) : $urandom_range(0, 15);
      a   = (idx << 2) | $urandom_range(0, 3);
      if (k == 0)                               transact(1, 1, a, $urandom, 0);
      else if (k < 5 || !(idx >= dep || known(idx))) transact(1, 0, a, $urandom, 0);
      else                                      transact(0, 1, a, 32'h0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
